spi_master: RTL and testbench

Single-clock SPI initiator that drives the serial side of the team's SPI slave/RAM subsystem. A host issues a 10-bit command word. The block frames it on SS_n, serialises it MSB-first on MOSI, and for read-data commands captures the 8-bit reply from MISO. It is the bench driver in the SPI UVM environment and the on-chip controller in the integrated SPI wrapper. The SPI shift clock is the system clk; no divided clock is generated.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_master.sv | 167 ++++++++++++++++
 tb/tb_spi_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame states, command opcodes and frame geometry.
package spi_pkg;

  localparam int unsigned CMD_BITS   = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned CMD_CYCLES = 2;
  localparam int unsigned CNT_W      = 4;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    SHIFT = 3'd2,
    TAIL  = 3'd3,
    TURN  = 3'd4,
    RECV  = 3'd5,
    END   = 3'd6
  } spi_state_e;

  // Opcode field of a command word.
  function automatic logic [1:0] cmd_opcode(input logic [CMD_BITS-1:0] word);
    return word[CMD_BITS-1 -: 2];
  endfunction

endpackage

// File: rtl/spi_master.sv
// SPI initiator: frames a 10-bit command on SS_n, shifts it out MSB-first on
// MOSI and, for rd-data commands, captures an 8-bit reply from MISO.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_TURN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] tx_word,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CMD_BITS-1:0]   word_q, word_d;
  logic [DATA_BITS-1:0]  shadow_q, shadow_d;
  logic [DATA_BITS-1:0]  rd_data_q, rd_data_d;
  logic                  ss_n_q, ss_n_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]      cnt_dec;
  logic                  is_rd_data;

  // Saturating decrement shared by every counted state.
  assign cnt_dec    = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
  assign is_rd_data = (cmd_opcode(word_q) == OP_RD_DATA);

  // Next-state, shift paths and registered-output values (derived from next state).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    shadow_d   = shadow_q;
    rd_data_d  = rd_data_q;
    ss_n_d     = 1'b1;
    mosi_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CMD;
          cnt_d   = CNT_W'(CMD_CYCLES - 1);
          word_d  = tx_word;
        end
      end
      CMD: begin
        if (cnt_q == '0) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(CMD_BITS - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          if (is_rd_data) begin
            state_d = TURN;
            cnt_d   = CNT_W'(RD_TURN - 1);
          end else begin
            state_d = TAIL;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      TAIL: begin
        state_d = END;
      end
      TURN: begin
        // The edge closing TURN takes the first (MSB) reply sample.
        if (cnt_q == '0) begin
          state_d  = RECV;
          cnt_d    = CNT_W'(DATA_BITS - 1);
          shadow_d = {shadow_q[DATA_BITS-2:0], MISO};
        end else begin
          cnt_d = cnt_dec;
        end
      end
      RECV: begin
        if (cnt_q == '0) begin
          state_d   = END;
          rd_data_d = shadow_q;
        end else begin
          cnt_d    = cnt_dec;
          shadow_d = {shadow_q[DATA_BITS-2:0], MISO};
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ss_n_d     = (state_d == IDLE) || (state_d == END);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == END);
    rd_valid_d = (state_d == END) && is_rd_data;

    case (state_d)
      CMD:     mosi_d = word_d[CMD_BITS-1];
      SHIFT:   mosi_d = word_d[cnt_d];
      default: mosi_d = 1'b0;
    endcase
  end

  // State, shift registers and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      shadow_q   <= '0;
      rd_data_q  <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef SIM
  // Framing invariants.
  a_ss_n_frame: assert property (@(posedge clk) disable iff (!rst_n)
    ss_n_q == ((state_q == IDLE) || (state_q == END)));
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |=> (state_q == IDLE));
  a_rdv_done: assert property (@(posedge clk) disable iff (!rst_n)
    rd_valid_q |-> done_q);
  a_idle_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) |-> !busy_q);
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master with a frame-level reference model
// and a behavioural SPI slave/RAM used for the loopback sequence.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned RD_TURN = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] tx_word;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ss_n;
  logic       mosi;
  logic       miso;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_rd;
  logic [7:0] ram [256];
  logic [7:0] slv_wr_addr;
  logic [7:0] slv_rd_addr;

  spi_master #(.RD_TURN(RD_TURN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tx_word  (tx_word),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected MOSI in cycle n after accept: two select cycles showing the MSB,
  // ten command bits MSB first, then zeros.
  function automatic logic exp_mosi(input logic [9:0] w, input int n);
    if (n <= 2) return w[9];
    if (n <= 12) return w[12-n];
    return 1'b0;
  endfunction

  // Slave/RAM behaviour: returns the byte it would send on a rd-data frame.
  function automatic logic [7:0] slave_apply(input logic [9:0] w);
    logic [7:0] reply;
    reply = 8'h00;
    case (w[9:8])
      OP_WR_ADDR: slv_wr_addr = w[7:0];
      OP_WR_DATA: ram[slv_wr_addr] = w[7:0];
      OP_RD_ADDR: slv_rd_addr = w[7:0];
      default:    reply = ram[slv_rd_addr];
    endcase
    return reply;
  endfunction

  // One frame, checked cycle by cycle from the accept. Entered just after a negedge.
  task automatic run_frame(input logic [9:0] w, input logic [7:0] miso_byte,
                           input bit hold, input bit poke, input int abort_at);
    bit         rd;
    int         last;
    int         waited;
    int         k;
    logic [9:0] rx;
    rd   = (w[9:8] == 2'b11);
    last = rd ? 21 + int'(RD_TURN) : 14;
    rx   = '0;
    start   = 1'b1;
    tx_word = w;
    waited  = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (busy !== 1'b1 && waited < 40);
    check("accept_latency", 32'(waited), 32'(1));
    if (!hold) start = 1'b0;
    tx_word = 10'($urandom);
    for (int n = 1; n <= last; n++) begin
      if (n > 1) @(negedge clk);
      check("ss_n", 32'(ss_n), 32'(n == last));
      check("done", 32'(done), 32'(n == last));
      check("rd_valid", 32'(rd_valid), 32'(rd && (n == last)));
      if (n < last) begin
        check("busy", 32'(busy), 32'(1));
        check("mosi", 32'(mosi), 32'(exp_mosi(w, n)));
      end
      if (n >= 3 && n <= 12) rx[12-n] = mosi;
      if (n == last) begin
        if (rd) exp_rd = miso_byte;
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        check("slave_rx", 32'(rx), 32'(w));
      end
      k = n - 12 - int'(RD_TURN);
      if (rd && k >= 0 && k < 8) miso = miso_byte[7-k];
      else miso = 1'($urandom);
      if (poke && n == 5) start = 1'b1;
      if (poke && n == 6 && !hold) start = 1'b0;
      if (n == abort_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        exp_rd = 8'h00;
        check("rst_ss_n", 32'(ss_n), 32'(1));
        check("rst_mosi", 32'(mosi), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("rst_no_done", 32'({done, rd_valid, ss_n}), 32'(3'b001));
        end
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    check("post_idle", 32'({ss_n, busy, done, rd_valid}), 32'(4'b1000));
  endtask

  initial begin
    logic [9:0] w;
    logic [7:0] b;
    rst_n   = 1'b0;
    start   = 1'b0;
    tx_word = '0;
    miso    = 1'b0;
    exp_rd  = 8'h00;
    slv_wr_addr = 8'h00;
    slv_rd_addr = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_ss_n", 32'(ss_n), 32'(1));
    check("reset_mosi", 32'(mosi), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done_rdv", 32'({done, rd_valid}), 32'(0));
    check("reset_rd_data", 32'(rd_data), 32'(0));
    rst_n = 1'b1;

    // Idle with no start.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      miso = 1'($urandom);
      check("idle", 32'({ss_n, mosi, busy, done, rd_valid}), 32'(5'b10000));
    end

    // wr-addr frame, then rd-data frame with a 0xA5 reply.
    run_frame(10'h0AB, 8'h00, 1'b0, 1'b0, 0);
    run_frame(10'h3C7, 8'hA5, 1'b0, 1'b0, 0);
    check("rd_data_a5", 32'(rd_data), 32'(8'hA5));

    // Mid-frame start ignored, then start held across two frames.
    run_frame(10'h1F0, 8'h00, 1'b0, 1'b1, 0);
    run_frame(10'h2C3, 8'h00, 1'b1, 1'b0, 0);
    run_frame(10'h3E1, 8'h5A, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("no_queued_frame", 32'({ss_n, busy}), 32'(2'b10));

    // Reset at T+8 of a rd-data frame, then a normal frame.
    run_frame(10'h3C7, 8'hFF, 1'b0, 1'b0, 8);
    run_frame(10'h2AB, 8'h00, 1'b0, 1'b0, 0);
    check("rd_data_after_rst", 32'(rd_data), 32'(0));

    // Loopback through the behavioural slave/RAM.
    b = slave_apply(10'h0AB); run_frame(10'h0AB, b, 1'b0, 1'b0, 0);
    b = slave_apply(10'h155); run_frame(10'h155, b, 1'b0, 1'b0, 0);
    b = slave_apply(10'h2AB); run_frame(10'h2AB, b, 1'b0, 1'b0, 0);
    b = slave_apply(10'h300); run_frame(10'h300, b, 1'b0, 1'b0, 0);
    check("loopback_rd_data", 32'(rd_data), 32'(ram[8'hAB]));
    check("loopback_byte", 32'(rd_data), 32'(8'h55));

    // Random command words and replies.
    for (int i = 0; i < 12; i++) begin
      w = 10'($urandom);
      if (i % 3 == 0) w[9:8] = 2'b11;
      b = 8'($urandom);
      run_frame(w, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("final_idle", 32'({ss_n, busy, done}), 32'(3'b100));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
